// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC selection, stallable PC register and a
// circular return-address stack that predicts return targets.
module pc_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned RESET_VECTOR = 32'h0,
  parameter int unsigned EXC_VECTOR   = 32'h80,
  parameter int unsigned INSTR_BYTES  = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           exception,
  input  logic                           branch_taken,
  input  logic [WIDTH-1:0]               branch_target,
  input  logic                           jump,
  input  logic [WIDTH-1:0]               jump_target,
  input  logic                           call,
  input  logic                           ret,
  input  logic [WIDTH-1:0]               link_addr,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_next,
  output logic                           redirect,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] STEP   = WIDTH'(INSTR_BYTES);
  localparam logic [CW-1:0]    FULL   = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_act;
  logic             pc_load;
  logic             non_seq;

  assign ptr_inc   = top_ptr + PW'(1);
  assign ptr_dec   = top_ptr - PW'(1);
  assign ras_top   = ras_mem[top_ptr];
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == FULL);

  // A taken branch or exception squashes whatever decode is doing with the RAS.
  assign ras_act = jump & ~stall & ~exception & ~branch_taken;
  assign pc_load = exception | ~stall;
  assign non_seq = exception | branch_taken | jump;

  // pc_next is the selected target; the stall only decides whether it is loaded.
  always_comb begin
    pc_next = pc + STEP;
    if (exception)
      pc_next = EXC_PC;
    else if (branch_taken)
      pc_next = branch_target;
    else if (jump && ret)
      pc_next = ras_empty ? jump_target : ras_top;
    else if (jump)
      pc_next = jump_target;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      pc       <= RST_PC;
      redirect <= 1'b0;
    end else if (pc_load) begin
      pc       <= pc_next;
      redirect <= non_seq;
    end
  end

  // RAS control: pointer, occupancy and sticky error flags.
  always_ff @(posedge clock) begin
    if (rst) begin
      top_ptr       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (ras_act) begin
      unique case ({call, ret})
        2'b10: begin
          top_ptr <= ptr_inc;
          if (ras_full) ras_overflow <= 1'b1;
          else          ras_count    <= ras_count + CW'(1);
        end
        2'b01: begin
          if (ras_empty) begin
            ras_underflow <= 1'b1;
          end else begin
            top_ptr   <= ptr_dec;
            ras_count <= ras_count - CW'(1);
          end
        end
        2'b11: begin
          if (ras_empty) begin
            ras_underflow <= 1'b1;
            top_ptr       <= ptr_inc;
            ras_count     <= CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // RAS storage: a full push lands on the oldest slot, which is what ptr_inc hits.
  always_ff @(posedge clock) begin
    if (!rst && ras_act && call) begin
      if (ret && !ras_empty) ras_mem[top_ptr] <= link_addr;
      else                   ras_mem[ptr_inc] <= link_addr;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: expected PC/redirect pairs are queued as each
// cycle's stimulus is driven and compared once the clock edge has updated pc.
module tb_pc_unit;

  localparam int W  = 32;
  localparam int CW = 3;

  typedef struct {
    logic [W-1:0] pc;
    logic         redir;
  } exp_t;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, exception = 1'b0, branch_taken = 1'b0;
  logic          jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [W-1:0]  branch_target = '0, jump_target = '0, link_addr = '0;
  logic [W-1:0]  pc, pc_next;
  logic          redirect, ras_overflow, ras_underflow;
  logic [CW-1:0] ras_count;

  logic          j8 = 1'b0;
  logic [7:0]    jt8 = '0;
  logic [7:0]    pc8, pc_next8;
  logic          redirect8, ovf8, unf8;
  logic [CW-1:0] cnt8;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  pc_unit dut (
    .clock(clock), .rst(rst), .stall(stall), .exception(exception),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
    .link_addr(link_addr), .pc(pc), .pc_next(pc_next), .redirect(redirect),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(0)) dut8 (
    .clock(clock), .rst(rst), .stall(1'b0), .exception(1'b0),
    .branch_taken(1'b0), .branch_target(8'h0),
    .jump(j8), .jump_target(jt8), .call(1'b0), .ret(1'b0),
    .link_addr(8'h0), .pc(pc8), .pc_next(pc_next8), .redirect(redirect8),
    .ras_count(cnt8), .ras_overflow(ovf8), .ras_underflow(unf8)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected result, compare after the edge.
  task automatic cyc(input logic s, input logic e, input logic b, input logic [W-1:0] bt,
                     input logic j, input logic [W-1:0] jt, input logic c, input logic r,
                     input logic [W-1:0] la, input logic [W-1:0] epc, input logic erd);
    exp_t x;
    stall = s; exception = e; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; call = c; ret = r; link_addr = la;
    x.pc = epc; x.redir = erd;
    q.push_back(x);
    @(posedge clock);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'(q.size()), 32'd1);
    end else begin
      x = q.pop_front();
      chk("pc", pc, x.pc);
      chk("redirect", {31'b0, redirect}, {31'b0, x.redir});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_redirect", {31'b0, redirect}, 32'h0);
    chk("rst_count", {29'b0, ras_count}, 32'h0);
    chk("rst_flags", {30'b0, ras_overflow, ras_underflow}, 32'h0);
    rst = 1'b0;

    // free running; the 8-bit instance jumps to 0xFC meanwhile
    j8 = 1'b1; jt8 = 8'hFC;
    cyc(0,0,0,0, 0,0,0,0,0, 32'h4, 0);
    chk("w8_jump", {24'b0, pc8}, 32'hFC);
    j8 = 1'b0;
    cyc(0,0,0,0, 0,0,0,0,0, 32'h8, 0);
    chk("w8_wrap", {24'b0, pc8}, 32'h00);
    cyc(0,0,0,0, 0,0,0,0,0, 32'hC, 0);
    chk("count_idle", {29'b0, ras_count}, 32'h0);

    // back to 8, stall twice, then branch
    cyc(0,0,0,0, 1,32'h8,0,0,0, 32'h8, 1);
    cyc(1,0,0,0, 0,0,0,0,0, 32'h8, 1);
    cyc(1,0,0,0, 0,0,0,0,0, 32'h8, 1);
    cyc(0,0,1,32'h100, 0,0,0,0,0, 32'h100, 1);
    cyc(0,0,0,0, 0,0,0,0,0, 32'h104, 0);

    // branch squashes a simultaneous call
    cyc(0,0,1,32'h200, 1,32'h300,1,0,32'h44, 32'h200, 1);
    chk("squash_count", {29'b0, ras_count}, 32'h0);

    // five calls into a four-entry RAS
    for (int i = 1; i <= 5; i++) begin
      cyc(0,0,0,0, 1,32'h400 + 32'(i*16),1,0,32'(i*16), 32'h400 + 32'(i*16), 1);
      if (i == 4) chk("ovf_before", {31'b0, ras_overflow}, 32'h0);
    end
    chk("count_full", {29'b0, ras_count}, 32'h4);
    chk("ovf_set", {31'b0, ras_overflow}, 32'h1);

    // five returns: four predicted, the last falls back to jump_target
    cyc(0,0,0,0, 1,32'hFFC,0,1,0, 32'h50, 1);
    cyc(0,0,0,0, 1,32'hFFC,0,1,0, 32'h40, 1);
    cyc(0,0,0,0, 1,32'hFFC,0,1,0, 32'h30, 1);
    cyc(0,0,0,0, 1,32'hFFC,0,1,0, 32'h20, 1);
    chk("unf_before", {31'b0, ras_underflow}, 32'h0);
    cyc(0,0,0,0, 1,32'hFFC,0,1,0, 32'hFFC, 1);
    chk("count_empty", {29'b0, ras_count}, 32'h0);
    chk("unf_set", {31'b0, ras_underflow}, 32'h1);

    // exception while stalled at 0x24 leaves the RAS alone
    cyc(0,0,0,0, 1,32'h20,1,0,32'h99, 32'h20, 1);
    cyc(0,0,0,0, 0,0,0,0,0, 32'h24, 0);
    cyc(1,1,0,0, 1,32'h700,1,0,32'h55, 32'h80, 1);
    chk("exc_count", {29'b0, ras_count}, 32'h1);
    cyc(0,0,0,0, 1,32'hFFC,0,1,0, 32'h99, 1);

    // call+ret: empty uses jump_target and pushes; non-empty swaps the top
    cyc(0,0,0,0, 1,32'h300,1,1,32'h60, 32'h300, 1);
    chk("cr_empty_count", {29'b0, ras_count}, 32'h1);
    cyc(0,0,0,0, 1,32'h500,1,1,32'h70, 32'h60, 1);
    chk("cr_count", {29'b0, ras_count}, 32'h1);
    cyc(0,0,0,0, 1,32'hFFC,0,1,0, 32'h70, 1);

    // call without jump is ignored; stalled call is held off
    cyc(0,0,0,0, 0,32'h900,1,0,32'h11, 32'h74, 0);
    cyc(1,0,0,0, 1,32'h900,1,0,32'h11, 32'h74, 0);
    chk("ignored_count", {29'b0, ras_count}, 32'h0);
    chk("sticky_flags", {30'b0, ras_overflow, ras_underflow}, 32'h3);

    // reset mid-operation wins over an exception and a call
    rst = 1'b1; exception = 1'b1; jump = 1'b1; call = 1'b1; stall = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_redirect", {31'b0, redirect}, 32'h0);
    chk("mid_rst_count", {29'b0, ras_count}, 32'h0);
    chk("mid_rst_flags", {30'b0, ras_overflow, ras_underflow}, 32'h0);
    rst = 1'b0;
    cyc(0,0,0,0, 0,0,0,0,0, 32'h4, 0);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
